// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one decoded access from execute to a valid/ready data-memory port.
// Define LSU_ALGEBRAIC_EN to make opcode 42 (lha, sign-extended half-word load) legal.
module lsu_mem_initiator #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_opcode,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        resp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       size_q;
    logic             sext_q;

    logic       dec_legal;
    logic       dec_load;
    logic [1:0] dec_size;
    logic       dec_sext;

    // size: 0 = byte, 1 = half, 2 = word, 3 = double
    always_comb begin
        dec_legal = 1'b1;
        dec_load  = 1'b0;
        dec_size  = 2'd0;
        dec_sext  = 1'b0;
        case (req_opcode)
            6'd34: begin dec_load = 1'b1; dec_size = 2'd0; end
            6'd40: begin dec_load = 1'b1; dec_size = 2'd1; end
            6'd32: begin dec_load = 1'b1; dec_size = 2'd2; end
            6'd58: begin dec_load = 1'b1; dec_size = 2'd3; end
            6'd38: dec_size = 2'd0;
            6'd44: dec_size = 2'd1;
            6'd36: dec_size = 2'd2;
            6'd62: dec_size = 2'd3;
`ifdef LSU_ALGEBRAIC_EN
            6'd42: begin dec_load = 1'b1; dec_size = 2'd1; dec_sext = 1'b1; end
`endif
            default: dec_legal = 1'b0;
        endcase
    end

    function automatic logic [63:0] size_data(input logic [63:0] d, input logic [1:0] sz,
                                              input logic sx);
        logic [63:0] r;
        case (sz)
            2'd0:    r = {56'd0, d[7:0]};
            2'd1:    r = sx ? {{48{d[15]}}, d[15:0]} : {48'd0, d[15:0]};
            2'd2:    r = {32'd0, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            size_q     <= 2'd0;
            sext_q     <= 1'b0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            mem_valid  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!req_ready) begin
                        req_ready <= 1'b1;
                    end else if (req_valid) begin
                        req_ready <= 1'b0;
                        size_q    <= dec_size;
                        sext_q    <= dec_sext;
                        cnt_q     <= '0;
                        if (dec_legal) begin
                            mem_valid <= 1'b1;
                            mem_read  <= dec_load;
                            mem_write <= ~dec_load;
                            mem_addr  <= req_addr;
                            mem_wdata <= size_data(req_wdata, dec_size, 1'b0);
                            state_q   <= StReq;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                            state_q    <= StResp;
                        end
                    end
                end
                StReq: begin
                    // A completion on the final allowed cycle beats the timeout.
                    if (mem_ready || cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        mem_valid  <= 1'b0;
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= ~mem_ready;
                        resp_data  <= (mem_ready && mem_read) ?
                                      size_data(mem_rdata, size_q, sext_q) : 64'd0;
                        cnt_q      <= '0;
                        state_q    <= StResp;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_data  <= '0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: directed accesses against a transaction-level model.
module tb_lsu_mem_initiator;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_opcode = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_data;
    logic        resp_err;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;

    lsu_mem_initiator #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    // Expectations for the transaction currently in flight.
    bit          cmp_en = 1'b0;
    bit          exp_load;
    logic [63:0] exp_addr;
    logic [63:0] exp_wdata;
    logic [63:0] exp_resp;
    bit          exp_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%016h, expected 0x%016h at %0t", name, act, req, $time);
    endtask

    // Spec-level view: operand width in bytes, zero- or sign-extended.
    function automatic void model(input logic [5:0] op, input logic [63:0] wd,
                                  input logic [63:0] rd, output bit legal, output bit load,
                                  output logic [63:0] wexp, output logic [63:0] rexp);
        int bytes;
        bit sx;
        logic [63:0] mask;
        legal = 1'b1; load = 1'b0; bytes = 8; sx = 1'b0;
        case (op)
            6'd34: begin load = 1'b1; bytes = 1; end
            6'd40: begin load = 1'b1; bytes = 2; end
            6'd32: begin load = 1'b1; bytes = 4; end
            6'd58: begin load = 1'b1; bytes = 8; end
            6'd38: bytes = 1;
            6'd44: bytes = 2;
            6'd36: bytes = 4;
            6'd62: bytes = 8;
`ifdef LSU_ALGEBRAIC_EN
            6'd42: begin load = 1'b1; bytes = 2; sx = 1'b1; end
`endif
            default: legal = 1'b0;
        endcase
        mask = (bytes == 8) ? {64{1'b1}} : ((64'd1 << (8 * bytes)) - 64'd1);
        wexp = wd & mask;
        rexp = 64'd0;
        if (legal && load) begin
            rexp = rd & mask;
            if (sx && rd[8 * bytes - 1]) rexp = rexp | ~mask;
        end
    endfunction

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            if (mem_read && mem_write) check("rd_wr_exclusive", 64'd1, 64'd0);
            if (mem_valid) begin
                check("mem_read", 64'(mem_read), 64'(exp_load));
                check("mem_write", 64'(mem_write), 64'(!exp_load));
                check("mem_addr", mem_addr, exp_addr);
                if (!exp_load) check("mem_wdata", mem_wdata, exp_wdata);
                check("no_resp_during_req", 64'(resp_valid), 64'd0);
            end
            if (resp_valid) begin
                check("resp_data", resp_data, exp_resp);
                check("resp_err", 64'(resp_err), 64'(exp_err));
                check("req_ready_in_resp", 64'(req_ready), 64'd0);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        check("req_ready_idle", 64'(req_ready), 64'd1);
    endtask

    // delay: REQ cycles before mem_ready pulses (>= TIMEOUT means never); hold: resp stall cycles
    task automatic do_access(input logic [5:0] op, input logic [63:0] addr,
                             input logic [63:0] wd, input logic [63:0] rd,
                             input int delay, input int hold);
        bit legal, load;
        logic [63:0] wexp, rexp;
        int mcyc;
        int exp_cyc;
        model(op, wd, rd, legal, load, wexp, rexp);
        wait_ready();
        exp_load  = load;
        exp_addr  = addr;
        exp_wdata = wexp;
        exp_err   = !legal || delay >= TIMEOUT;
        exp_resp  = exp_err ? 64'd0 : rexp;
        cmp_en    = 1'b1;
        req_valid = 1'b1; req_opcode = op; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_wdata = {$urandom, $urandom};
        check("req_ready_after_accept", 64'(req_ready), 64'd0);
        mcyc = 0;
        while (mem_valid && mcyc < 40) begin
            mem_ready = (mcyc == delay);
            mem_rdata = (mcyc == delay) ? rd : {$urandom, $urandom};
            mcyc++;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        exp_cyc = !legal ? 0 : (delay >= TIMEOUT ? TIMEOUT : delay + 1);
        check("mem_valid_cycles", 64'(mcyc), 64'(exp_cyc));
        check("resp_valid", 64'(resp_valid), 64'd1);
        for (int i = 0; i < hold; i++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            check("resp_valid_held", 64'(resp_valid), 64'd1);
            check("mem_idle_in_resp", 64'(mem_valid), 64'd0);
        end
        mem_ready = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_valid_drop", 64'(resp_valid), 64'd0);
        check("resp_data_clear", resp_data, 64'd0);
        check("resp_err_clear", 64'(resp_err), 64'd0);
        check("req_ready_return", 64'(req_ready), 64'd1);
    endtask

    initial begin
        bit l, ld;
        logic [63:0] w, r;

        // Pin the model to hand-computed values.
        model(6'd38, 64'hDEADBEEFCAFEF00D, 64'd0, l, ld, w, r);
        check("model_stb_wdata", w, 64'h0D);
        model(6'd32, 64'd0, 64'h1122334455667788, l, ld, w, r);
        check("model_lwz_rdata", r, 64'h0000000055667788);
        model(6'd40, 64'd0, 64'hFFFFFFFFFFFF8001, l, ld, w, r);
        check("model_lhz_rdata", r, 64'h8001);
        model(6'd31, 64'd0, 64'd0, l, ld, w, r);
        check("model_illegal", 64'(l), 64'd0);
        model(6'd42, 64'd0, 64'hFFFFFFFFFFFF8001, l, ld, w, r);
`ifdef LSU_ALGEBRAIC_EN
        check("model_lha_rdata", r, 64'hFFFFFFFFFFFF8001);
`else
        check("model_lha_illegal", 64'(l), 64'd0);
`endif

        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("req_ready_first_edge", 64'(req_ready), 64'd1);

        do_access(6'd38, 64'd3, 64'hDEADBEEFCAFEF00D, 64'd0, 0, 0);
        do_access(6'd32, 64'd2, 64'd0, 64'h1122334455667788, 0, 0);
        do_access(6'd58, 64'd9, 64'd0, 64'hA5A5A5A5A5A5A5A5, 100, 0);
        do_access(6'd31, 64'd1, 64'd0, 64'd0, 0, 1);
        do_access(6'd40, 64'd4, 64'd0, 64'hFFFFFFFFFFFF8001, 2, 5);
        do_access(6'd42, 64'd5, 64'd0, 64'hFFFFFFFFFFFF8001, 1, 0);
        do_access(6'd34, 64'd6, 64'd0, 64'h00000000000000F7, TIMEOUT - 1, 0);
        do_access(6'd62, 64'd7, 64'h0123456789ABCDEF, 64'd0, 3, 2);
        do_access(6'd44, 64'd8, 64'hFFFFFFFFFFFF1234, 64'd0, TIMEOUT, 0);
        do_access(6'd36, 64'hFFFF, 64'h8765432112345678, 64'd0, 1, 0);

        // Reset while a load is waiting on memory.
        wait_ready();
        cmp_en = 1'b0;
        req_valid = 1'b1; req_opcode = 6'd58; req_addr = 64'd11;
        @(negedge clk);
        req_valid = 1'b0;
        check("mem_valid_before_rst", 64'(mem_valid), 64'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_mem_valid", 64'(mem_valid), 64'd0);
        check("async_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("async_rst_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("req_ready_after_release", 64'(req_ready), 64'd1);
        check("no_resp_after_rst", 64'(resp_valid), 64'd0);
        do_access(6'd58, 64'd12, 64'd0, 64'hCAFEBABE00C0FFEE, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
